cmd_seq: RTL
============

# cmd_seq

Parametrised command-script sequencer that plays a buffered list of 16-bit Knight commands into `RemoteComm`. It issues one command per step, waits for `cmd_sent`, then waits for a response with a timeout, and checks the response against the positive acknowledge. It sits between bench or host control logic and `RemoteComm`. It generalises the single calibrate-and-check flow to an N-entry script with error reporting.

## Interface
- `DEPTH`, 8: script entries, minimum 2.
- `TMO_W`, 20: timeout counter width. Timeout occurs after 2^TMO_W−1 cycles in one wait state.
- `ACK`, 8'hA5: positive acknowledge value.

- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `load`  in  1  write `load_data` to the next script slot.
- `load_data`  in  16  command to store.
- `clr`  in  1  empty the script.
- `start`  in  1  play the script from entry 0.
- `abort`  in  1  stop play immediately.
- `cmd`  out  16  command presented to `RemoteComm`.
- `send_cmd`  out  1  one-cycle send pulse.
- `cmd_sent`  in  1  `RemoteComm` transmit complete.
- `resp_rdy`  in  1  response valid.
- `resp`  in  8  response byte.
- `busy`  out  1  high from `start` accepted until done.
- `done`  out  1  one-cycle pulse at the end of play.
- `err`  out  1  sticky error flag, cleared on an accepted `start`.
- `err_code`  out  2  00 none, 01 NACK, 10 timeout, 11 abort.
- `err_idx`  out  $clog2(DEPTH)  index of the failing entry.
- `cnt`  out  $clog2(DEPTH+1)  number of entries loaded.
- `load_ovf`  out  1  one-cycle pulse when `load` is dropped.

## Operation
- States: IDLE, SEND, WAIT_SENT, WAIT_RESP, NEXT, FIN.
- **Script buffer**
  - `load`, `clr` and `start` act only in IDLE.
  - `load` with `cnt`==DEPTH is dropped and pulses `load_ovf`.
  - `clr` takes priority over `load` in the same cycle.
  - Buffer contents survive play, so a script can be replayed.
- **Start**
  - `start` in IDLE clears `err`, `err_code` and `err_idx`, and sets index 0.
  - If `cnt`==0, go straight to FIN.
  - Otherwise go to SEND.
- **SEND**
  - Drive `cmd` = buf[idx] and pulse `send_cmd`, then go to WAIT_SENT.
  - `cmd` holds its value until the next SEND.
- **WAIT_SENT**: on `cmd_sent`, go to WAIT_RESP.
- **WAIT_RESP**
  - `resp_rdy` with `resp`==ACK goes to NEXT.
  - `resp_rdy` with any other value: `err_code`=01, go to FIN.
- **Timeout**
  - The timeout counter clears on entry to each wait state.
  - Saturation in WAIT_SENT or WAIT_RESP: `err_code`=10, go to FIN.
- **NEXT**
  - idx+1==`cnt` goes to FIN.
  - Otherwise increment idx and go to SEND.
- **FIN**: pulse `done`, deassert `busy`, return to IDLE.
- **Errors**: `err` sets on any nonzero `err_code`, and `err_idx` latches idx.
- **Abort**
  - `abort` in any non-IDLE state forces FIN next cycle with `err_code`=11.
  - `abort` has priority over `resp_rdy` and timeout in the same cycle.
  - `abort` in IDLE is ignored.
- **Extra handshakes**: `resp_rdy` or `cmd_sent` outside their wait states is ignored.

## Timing
- **Reset values**
  - `cmd`=0, `send_cmd`=0, `busy`=0, `done`=0, `err`=0, `err_code`=0, `err_idx`=0, `cnt`=0, `load_ovf`=0.
  - Script buffer contents are don't-care.
  - State returns to IDLE.
- `start` to `send_cmd`: 2 cycles (IDLE→SEND registered, `send_cmd` registered).
- Response accepted to next `send_cmd`: 3 cycles.
- Last response to `done`: 2 cycles.
- **Reset mid-play**: all outputs return to reset values asynchronously. No `done` pulse is produced.

## Configuration
- `CMD_SEQ_RETRY_EN`
  - Defined: a NACK or timeout on an entry re-enters SEND for that entry once. An error is flagged only if the retry also fails. Abort never retries.
  - Undefined: the first NACK or timeout ends play.

## Structure
- Package `cmd_seq_pkg`: state enum `seq_state_t`, error-code enum `seq_err_t`, constant `POS_ACK`=8'hA5.
- Sub-module `tmo_timer`: TMO_W-bit counter with a clear input and a saturation flag.

## Test plan
- **Reset**: assert `rst_n`=0 mid-WAIT_RESP → all outputs at reset values, `busy`=0, no `done`.
- **Two-entry script**
  - Stimulus: load 16'h2000 then 16'h4001, `start`, ACK 8'hA5 each time.
  - Required: two `send_cmd` pulses with `cmd` 2000 then 4001, then `done`, `err`=0.
- **NACK**
  - Stimulus: 3 entries, `resp`=8'h5A on entry 1.
  - Required: `done`, `err`=1, `err_code`=01, `err_idx`=1, only 2 sends.
- **Timeout**
  - Stimulus: TMO_W=4, `cmd_sent` never asserted.
  - Required: `done` after 15 cycles in WAIT_SENT, `err_code`=10, `err_idx`=0.
- **Abort and overflow**
  - Abort in WAIT_RESP → `err_code`=11, `done` next cycle.
  - Ninth `load` with DEPTH=8 → `load_ovf` pulse, `cnt` stays 8.
- **Retry**
  - Stimulus: `CMD_SEQ_RETRY_EN` defined, NACK then ACK on entry 0.
  - Required: 2 sends of the same `cmd`, `err`=0.

Source files
------------

// File: rtl/cmd_seq_pkg.sv
// Shared types and constants for the command-script sequencer.
package cmd_seq_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND      = 3'd1,
        WAIT_SENT = 3'd2,
        WAIT_RESP = 3'd3,
        NEXT      = 3'd4,
        FIN       = 3'd5
    } seq_state_t;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'b00,
        ERR_NACK  = 2'b01,
        ERR_TMO   = 2'b10,
        ERR_ABORT = 2'b11
    } seq_err_t;

    localparam logic [7:0] POS_ACK = 8'hA5;

endpackage

// File: rtl/cmd_seq_tmo_timer.sv
// Wait-state timeout counter: saturating W-bit count with synchronous clear.
module tmo_timer #(
    parameter int W = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic sat
);

    logic [W-1:0] count_q;

    assign sat = &count_q;

    // Clear loads 1 so the entry cycle is counted: saturation lands exactly
    // 2^W-1 cycles after entering a wait state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= W'(1);
        end else if (en && !sat) begin
            count_q <= count_q + W'(1);
        end
    end

endmodule

// File: rtl/cmd_seq.sv
// Command-script sequencer: plays a buffered list of 16-bit commands into
// RemoteComm, waiting for transmit-complete and an acknowledge per entry.
// Optional feature macro: CMD_SEQ_RETRY_EN (one retry per entry on NACK/timeout).
module cmd_seq
    import cmd_seq_pkg::*;
#(
    parameter int         DEPTH = 8,
    parameter int         TMO_W = 20,
    parameter logic [7:0] ACK   = POS_ACK,
    localparam int        IW    = $clog2(DEPTH),
    localparam int        CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [15:0]   load_data,
    input  logic          clr,
    input  logic          start,
    input  logic          abort,
    output logic [15:0]   cmd,
    output logic          send_cmd,
    input  logic          cmd_sent,
    input  logic          resp_rdy,
    input  logic [7:0]    resp,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [1:0]    err_code,
    output logic [IW-1:0] err_idx,
    output logic [CW-1:0] cnt,
    output logic          load_ovf
);

    seq_state_t    state_q, state_nx;
    logic [IW-1:0] idx_q;
    logic [CW-1:0] cnt_q;
    logic [15:0]   script_q [DEPTH];
    seq_err_t      err_code_q, err_code_nx, fail_code;
    logic          fail, set_err, idx_inc;
    logic          tmr_clr, tmr_en, tmr_sat;
    logic          load_ok;
`ifdef CMD_SEQ_RETRY_EN
    logic          retried_q, retry_take;
`endif

    assign cnt      = cnt_q;
    assign err_code = err_code_q;
    assign load_ok  = (state_q == IDLE) && !clr && load && (cnt_q != CW'(DEPTH));

    tmo_timer #(.W(TMO_W)) u_tmo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .sat   (tmr_sat)
    );

    // Next-state logic, error resolution and timer control.
    always_comb begin
        state_nx    = state_q;
        fail        = 1'b0;
        fail_code   = ERR_NONE;
        set_err     = 1'b0;
        err_code_nx = ERR_NONE;
        idx_inc     = 1'b0;
`ifdef CMD_SEQ_RETRY_EN
        retry_take  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start) state_nx = (cnt_q == '0) ? FIN : SEND;
            end
            SEND: state_nx = WAIT_SENT;
            WAIT_SENT: begin
                if (cmd_sent) begin
                    state_nx = WAIT_RESP;
                end else if (tmr_sat) begin
                    fail      = 1'b1;
                    fail_code = ERR_TMO;
                end
            end
            WAIT_RESP: begin
                if (resp_rdy) begin
                    if (resp == ACK) begin
                        state_nx = NEXT;
                    end else begin
                        fail      = 1'b1;
                        fail_code = ERR_NACK;
                    end
                end else if (tmr_sat) begin
                    fail      = 1'b1;
                    fail_code = ERR_TMO;
                end
            end
            NEXT: begin
                if (CW'(idx_q) + CW'(1) == cnt_q) begin
                    state_nx = FIN;
                end else begin
                    state_nx = SEND;
                    idx_inc  = 1'b1;
                end
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        // Abort overrides any handshake or timeout; FIN is already ending play.
        if (abort && (state_q != IDLE) && (state_q != FIN)) begin
            state_nx    = FIN;
            idx_inc     = 1'b0;
            set_err     = 1'b1;
            err_code_nx = ERR_ABORT;
        end else if (fail) begin
`ifdef CMD_SEQ_RETRY_EN
            if (!retried_q) begin
                state_nx   = SEND;
                retry_take = 1'b1;
            end else
`endif
            begin
                state_nx    = FIN;
                set_err     = 1'b1;
                err_code_nx = fail_code;
            end
        end

        tmr_en  = (state_q == WAIT_SENT) || (state_q == WAIT_RESP);
        tmr_clr = (state_nx != state_q) &&
                  ((state_nx == WAIT_SENT) || (state_nx == WAIT_RESP));
    end

    // State, index, script count and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            cmd        <= '0;
            send_cmd   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            err_code_q <= ERR_NONE;
            err_idx    <= '0;
            load_ovf   <= 1'b0;
        end else begin
            state_q  <= state_nx;
            send_cmd <= (state_q == SEND) && (state_nx == WAIT_SENT);
            done     <= (state_nx == FIN);
            busy     <= state_nx inside {SEND, WAIT_SENT, WAIT_RESP, NEXT};
            load_ovf <= 1'b0;
            if ((state_q == SEND) && (state_nx == WAIT_SENT)) begin
                cmd <= script_q[idx_q];
            end
            if (state_q == IDLE) begin
                if (clr) begin
                    cnt_q <= '0;
                end else if (load) begin
                    if (cnt_q == CW'(DEPTH)) load_ovf <= 1'b1;
                    else                     cnt_q    <= cnt_q + CW'(1);
                end
                if (start) begin
                    idx_q      <= '0;
                    err        <= 1'b0;
                    err_code_q <= ERR_NONE;
                    err_idx    <= '0;
                end
            end
            if (idx_inc) idx_q <= idx_q + IW'(1);
            if (set_err) begin
                err        <= 1'b1;
                err_code_q <= err_code_nx;
                err_idx    <= idx_q;
            end
        end
    end

    // Script storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (load_ok) script_q[cnt_q[IW-1:0]] <= load_data;
    end

`ifdef CMD_SEQ_RETRY_EN
    // One retry per entry: armed on each new entry and at every new play.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retried_q <= 1'b0;
        end else if ((state_q == IDLE) || idx_inc) begin
            retried_q <= 1'b0;
        end else if (retry_take) begin
            retried_q <= 1'b1;
        end
    end
`endif

endmodule
